// File: rtl/load_store_unit.sv
// RV32 load/store unit: decodes funct3, checks alignment, drives a single-request memory port
// with lane enables/replication, extends load data and reports faults on a one-cycle done pulse.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Valid,
    input  logic        i_Write,
    input  logic [2:0]  i_Funct,
    input  logic [31:0] i_Address,
    input  logic [31:0] i_StoreData,
    output logic        o_Ready,
    output logic        o_Done,
    output logic [31:0] o_LoadData,
    output logic        o_Misaligned,
    output logic        o_IllegalFunct,
    output logic        o_BusError,
    output logic        o_MemReq,
    output logic        o_MemWrite,
    output logic [31:0] o_MemAddress,
    output logic [3:0]  o_MemByteEnable,
    output logic [31:0] o_MemWriteData,
    input  logic        i_MemAck,
    input  logic [31:0] i_MemReadData
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESPOND = 2'd2} state_t;

    // Counter value on the last permitted wait cycle; an ack on that cycle still wins.
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 32'd1);

    state_t      state_r, nextState_s;
    logic [7:0]  waitCount_r, waitCountNext_s;
    logic [1:0]  reqOffset_r, reqOffsetNext_s;
    logic [2:0]  reqFunct_r, reqFunctNext_s;
    logic        reqWrite_r, reqWriteNext_s;
    logic [31:0] memAddress_r, memAddressNext_s;
    logic [3:0]  byteEnable_r, byteEnableNext_s;
    logic [31:0] writeData_r, writeDataNext_s;
    logic        memWrite_r, memWriteNext_s;
    logic        done_r, doneNext_s;
    logic        misaligned_r, misalignedNext_s;
    logic        illegal_r, illegalNext_s;
    logic        busError_r, busErrorNext_s;
    logic [31:0] loadData_r, loadDataNext_s;

    function automatic logic isIllegal(input logic write, input logic [2:0] funct);
        logic result;
        case (funct)
            3'b000, 3'b001, 3'b010: result = 1'b0;
            3'b100, 3'b101:         result = write;
            default:                result = 1'b1;
        endcase
        return result;
    endfunction

    function automatic logic isMisaligned(input logic [2:0] funct, input logic [1:0] offset);
        logic result;
        case (funct[1:0])
            2'b01:   result = offset[0];
            2'b10:   result = (offset != 2'b00);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    function automatic logic [3:0] laneEnable(input logic [2:0] funct, input logic [1:0] offset);
        logic [3:0] result;
        case (funct[1:0])
            2'b00:   result = 4'b0001 << offset;
            2'b01:   result = 4'b0011 << offset;
            2'b10:   result = 4'b1111;
            default: result = 4'b0000;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] replicate(input logic [2:0] funct, input logic [31:0] data);
        logic [31:0] result;
        case (funct[1:0])
            2'b00:   result = {4{data[7:0]}};
            2'b01:   result = {2{data[15:0]}};
            2'b10:   result = data;
            default: result = 32'h0000_0000;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] extractLoad(input logic [2:0] funct, input logic [1:0] offset,
                                                input logic [31:0] word);
        logic [7:0]  laneByte;
        logic [15:0] laneHalf;
        logic [31:0] result;
        case (offset)
            2'b00:   laneByte = word[7:0];
            2'b01:   laneByte = word[15:8];
            2'b10:   laneByte = word[23:16];
            2'b11:   laneByte = word[31:24];
            default: laneByte = 8'h00;
        endcase
        if (offset[1]) begin
            laneHalf = word[31:16];
        end else begin
            laneHalf = word[15:0];
        end
        case (funct)
            3'b000:  result = {{24{laneByte[7]}}, laneByte};
            3'b001:  result = {{16{laneHalf[15]}}, laneHalf};
            3'b010:  result = word;
            3'b100:  result = {24'h00_0000, laneByte};
            3'b101:  result = {16'h0000, laneHalf};
            default: result = 32'h0000_0000;
        endcase
        return result;
    endfunction

    // State register.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state and next-value logic for the captured request and all registered outputs.
    always_comb begin
        nextState_s      = state_r;
        waitCountNext_s  = waitCount_r;
        reqOffsetNext_s  = reqOffset_r;
        reqFunctNext_s   = reqFunct_r;
        reqWriteNext_s   = reqWrite_r;
        memAddressNext_s = memAddress_r;
        byteEnableNext_s = byteEnable_r;
        writeDataNext_s  = writeData_r;
        memWriteNext_s   = memWrite_r;
        doneNext_s       = 1'b0;
        misalignedNext_s = 1'b0;
        illegalNext_s    = 1'b0;
        busErrorNext_s   = 1'b0;
        loadDataNext_s   = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                if (i_Valid) begin
                    reqOffsetNext_s = i_Address[1:0];
                    reqFunctNext_s  = i_Funct;
                    reqWriteNext_s  = i_Write;
                    if (isIllegal(i_Write, i_Funct)) begin
                        nextState_s   = RESPOND;
                        doneNext_s    = 1'b1;
                        illegalNext_s = 1'b1;
                    end else if (isMisaligned(i_Funct, i_Address[1:0])) begin
                        nextState_s      = RESPOND;
                        doneNext_s       = 1'b1;
                        misalignedNext_s = 1'b1;
                    end else begin
                        nextState_s      = ACCESS;
                        waitCountNext_s  = 8'd0;
                        memAddressNext_s = {i_Address[31:2], 2'b00};
                        byteEnableNext_s = laneEnable(i_Funct, i_Address[1:0]);
                        writeDataNext_s  = replicate(i_Funct, i_StoreData);
                        memWriteNext_s   = i_Write;
                    end
                end else begin
                    nextState_s = IDLE;
                end
            end
            ACCESS: begin
                if (i_MemAck || (waitCount_r == WAIT_LIMIT)) begin
                    nextState_s      = RESPOND;
                    doneNext_s       = 1'b1;
                    memAddressNext_s = 32'h0000_0000;
                    byteEnableNext_s = 4'b0000;
                    writeDataNext_s  = 32'h0000_0000;
                    memWriteNext_s   = 1'b0;
                    if (i_MemAck) begin
                        loadDataNext_s = reqWrite_r ? 32'h0000_0000
                                                    : extractLoad(reqFunct_r, reqOffset_r, i_MemReadData);
                    end else begin
                        busErrorNext_s = 1'b1;
                    end
                end else begin
                    waitCountNext_s = waitCount_r + 8'd1;
                end
            end
            RESPOND: begin
                nextState_s = IDLE;
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            waitCount_r  <= 8'd0;
            reqOffset_r  <= 2'b00;
            reqFunct_r   <= 3'b000;
            reqWrite_r   <= 1'b0;
            memAddress_r <= 32'h0000_0000;
            byteEnable_r <= 4'b0000;
            writeData_r  <= 32'h0000_0000;
            memWrite_r   <= 1'b0;
            done_r       <= 1'b0;
            misaligned_r <= 1'b0;
            illegal_r    <= 1'b0;
            busError_r   <= 1'b0;
            loadData_r   <= 32'h0000_0000;
        end else begin
            waitCount_r  <= waitCountNext_s;
            reqOffset_r  <= reqOffsetNext_s;
            reqFunct_r   <= reqFunctNext_s;
            reqWrite_r   <= reqWriteNext_s;
            memAddress_r <= memAddressNext_s;
            byteEnable_r <= byteEnableNext_s;
            writeData_r  <= writeDataNext_s;
            memWrite_r   <= memWriteNext_s;
            done_r       <= doneNext_s;
            misaligned_r <= misalignedNext_s;
            illegal_r    <= illegalNext_s;
            busError_r   <= busErrorNext_s;
            loadData_r   <= loadDataNext_s;
        end
    end

    assign o_Ready         = (state_r == IDLE);
    assign o_MemReq        = (state_r == ACCESS);
    assign o_Done          = done_r;
    assign o_LoadData      = loadData_r;
    assign o_Misaligned    = misaligned_r;
    assign o_IllegalFunct  = illegal_r;
    assign o_BusError      = busError_r;
    assign o_MemWrite      = memWrite_r;
    assign o_MemAddress    = memAddress_r;
    assign o_MemByteEnable = byteEnable_r;
    assign o_MemWriteData  = writeData_r;

endmodule
